// File: rtl/etherneco_synctimer_master_core.sv
// EtherNeco sync-timer ring master: transmits the time/offset command frame, snoops the
// response for per-node elapsed times and derives offsets. Option: ETHERNECO_SYNCTIMER_MASTER_LPF_EN.
module etherneco_synctimer_master_core #(
   parameter int          TIMER_WIDTH     = 64,
   parameter int          MAX_NODES       = 16,
   parameter logic [31:0] TIME_COMPENSATE = 32'd0,
   parameter int          LPF_GAIN        = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TIMER_WIDTH-1:0] current_time,
   input  logic [7:0]             param_node_count,
   input  logic                   start_trigger,
   input  logic                   start_renew,
   output logic                   busy,
   output logic                   m_cmd_first,
   output logic                   m_cmd_last,
   output logic [7:0]             m_cmd_data,
   output logic                   m_cmd_valid,
   input  logic                   m_cmd_ready,
   input  logic                   res_rx_start,
   input  logic                   res_rx_end,
   input  logic                   res_rx_error,
   input  logic [15:0]            s_res_pos,
   input  logic [7:0]             s_res_data,
   input  logic                   s_res_valid,
   output logic                   offsets_valid,
   input  logic [7:0]             mon_node,
   output logic [31:0]            mon_offset,
   output logic [31:0]            mon_round_trip
);
   localparam int IDX_W  = 16;
   localparam int NODE_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam int CNT_W  = NODE_W + 1;

   if (TIMER_WIDTH < 32 || LPF_GAIN < 0 || LPF_GAIN > 31) begin : g_param_check
      $error("etherneco_synctimer_master_core: illegal TIMER_WIDTH or LPF_GAIN");
   end

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_CALC} state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              renew_q, renew_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NODE_W-1:0] calc_q, calc_d;
   logic [63:0]       tx_time_q, tx_time_d;
   logic [31:0]       t_start_q, t_start_d;
   logic [31:0]       round_trip_q, round_trip_d;
   logic [31:0]       mon_rt_q, mon_rt_d;
   logic              ov_q, ov_d;
   logic              valid_q, valid_d, first_q, first_d, last_q, last_d;
   logic [7:0]        data_q, data_d;
   logic [31:0]       offset_q  [MAX_NODES];
   logic [31:0]       offset_d  [MAX_NODES];
   logic [31:0]       elapsed_q [MAX_NODES];
   logic [31:0]       elapsed_d [MAX_NODES];

   logic [IDX_W-1:0]  last_idx, next_idx, tx_rel, rx_rel;
   logic [NODE_W-1:0] rx_node;
   logic              rx_hit;
   logic [7:0]        next_byte;
   logic [CNT_W-1:0]  n_clamped;
   logic [31:0]       new_offset;

   assign last_idx   = IDX_W'(8) + (IDX_W'(n_q) << 2);
   assign next_idx   = idx_q + IDX_W'(1);
   assign tx_rel     = next_idx - IDX_W'(9);
   assign rx_rel     = s_res_pos - IDX_W'(9);
   assign rx_node    = rx_rel[NODE_W+1:2];
   assign rx_hit     = s_res_valid && (s_res_pos >= IDX_W'(9)) &&
                       ({2'b00, rx_rel[IDX_W-1:2]} < IDX_W'(n_q));
   assign new_offset = (round_trip_q - elapsed_q[calc_q]) >> 1;

`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
   logic signed [31:0] lpf_delta;
   // Arithmetic shift must see a signed operand on its own, not inside the unsigned sum.
   assign lpf_delta = $signed(new_offset - offset_q[calc_q]) >>> LPF_GAIN;
`endif

   always_comb begin
      if (param_node_count == 8'd0)                  n_clamped = CNT_W'(1);
      else if (int'(param_node_count) > MAX_NODES)   n_clamped = CNT_W'(MAX_NODES);
      else                                           n_clamped = CNT_W'(param_node_count);
   end

   // Byte that follows the one currently on the bus: time bytes 1..8, then node offsets.
   always_comb begin
      next_byte = 8'h00;
      if (next_idx <= IDX_W'(8))
         next_byte = tx_time_q[{next_idx[2:0] - 3'd1, 3'b000} +: 8];
      else if ({2'b00, tx_rel[IDX_W-1:2]} < IDX_W'(MAX_NODES))
         next_byte = offset_q[tx_rel[NODE_W+1:2]][{tx_rel[1:0], 3'b000} +: 8];
   end

   always_comb begin
      mon_offset = 32'd0;
      if (mon_node != 8'd0 && int'(mon_node) <= MAX_NODES)
         mon_offset = offset_q[NODE_W'(mon_node - 8'd1)];
   end

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a latch.
      state_d = state_q;       busy_d       = busy_q;       renew_d  = renew_q;
      n_d     = n_q;           idx_d        = idx_q;        calc_d   = calc_q;
      tx_time_d = tx_time_q;   t_start_d    = t_start_q;    round_trip_d = round_trip_q;
      mon_rt_d  = mon_rt_q;    ov_d         = ov_q;         data_d   = data_q;
      valid_d = valid_q;       first_d      = first_q;      last_d   = last_q;
      offset_d  = offset_q;
      elapsed_d = elapsed_q;
      unique case (state_q)
         S_IDLE: if (start_trigger) begin
            renew_d   = start_renew;
            n_d       = n_clamped;
            tx_time_d = 64'(current_time + TIMER_WIDTH'(TIME_COMPENSATE));
            idx_d     = '0;
            data_d    = {6'b0, start_renew, ov_q};
            valid_d   = 1'b1;
            first_d   = 1'b1;
            last_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_SEND;
         end
         S_SEND: if (valid_q && m_cmd_ready) begin
            if (idx_q == '0) t_start_d = current_time[31:0];
            if (last_q) begin
               valid_d = 1'b0;
               first_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_WAIT;
            end else begin
               idx_d   = next_idx;
               data_d  = next_byte;
               first_d = 1'b0;
               last_d  = (next_idx == last_idx);
            end
         end
         S_WAIT: if (res_rx_start) begin
            round_trip_d = current_time[31:0] - t_start_q;
            state_d      = S_RECV;
         end
         S_RECV: begin
            if (rx_hit) elapsed_d[rx_node][{rx_rel[1:0], 3'b000} +: 8] = s_res_data;
            if (res_rx_error) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (res_rx_end) begin
               calc_d  = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
            if (ov_q) offset_d[calc_q] = offset_q[calc_q] + $unsigned(lpf_delta);
            else      offset_d[calc_q] = new_offset;
`else
            offset_d[calc_q] = new_offset;
`endif
            calc_d = calc_q + NODE_W'(1);
            if ({1'b0, calc_q} == n_q - CNT_W'(1)) begin
               mon_rt_d = round_trip_q;
               ov_d     = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking updates so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;   busy_q  <= 1'b0;  renew_q <= 1'b0;  n_q <= CNT_W'(1);
         idx_q   <= '0;       calc_q  <= '0;    tx_time_q <= '0;  t_start_q <= '0;
         round_trip_q <= '0;  mon_rt_q <= '0;   ov_q <= 1'b0;     data_q <= '0;
         valid_q <= 1'b0;     first_q <= 1'b0;  last_q <= 1'b0;
         // NOTE: the offset/elapsed tables are reset because offsets are transmitted as-is.
         for (int i = 0; i < MAX_NODES; i++) begin
            offset_q[i]  <= '0;
            elapsed_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;  busy_q  <= busy_d;  renew_q <= renew_d;  n_q <= n_d;
         idx_q   <= idx_d;    calc_q  <= calc_d;  tx_time_q <= tx_time_d;  t_start_q <= t_start_d;
         round_trip_q <= round_trip_d;  mon_rt_q <= mon_rt_d;  ov_q <= ov_d;  data_q <= data_d;
         valid_q <= valid_d;  first_q <= first_d; last_q <= last_d;
         offset_q  <= offset_d;
         elapsed_q <= elapsed_d;
      end
   end

   assign busy           = busy_q;
   assign m_cmd_valid    = valid_q;
   assign m_cmd_first    = first_q;
   assign m_cmd_last     = last_q;
   assign m_cmd_data     = data_q;
   assign offsets_valid  = ov_q;
   assign mon_round_trip = mon_rt_q;
endmodule

// File: tb/tb_etherneco_synctimer_master_core.sv
// Directed bench for etherneco_synctimer_master_core: frame layout, back-pressure,
// round-trip/offset arithmetic, abort, ignored triggers, async reset and node-count clamping.
module tb_etherneco_synctimer_master_core;
   localparam int MAX_NODES = 16;

`ifdef ETHERNECO_SYNCTIMER_MASTER_LPF_EN
   localparam logic [31:0] EXP_R3_OFF1 = 32'd150;        // 300 + (300-300)... from 100: 100 + (200>>>2)
   localparam logic [31:0] EXP_R3_OFF2 = 32'h2000_00E0;  // 300 + ((0x7FFFFFFF-300)>>>2)
`else
   localparam logic [31:0] EXP_R3_OFF1 = 32'd300;        // (1010-410)/2
   localparam logic [31:0] EXP_R3_OFF2 = 32'h7FFF_FFFF;  // (1010-1012) wraps, then >>1
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] current_time = '0;
   logic [7:0]  param_node_count = 8'd2;
   logic        start_trigger = 1'b0, start_renew = 1'b0;
   logic        busy, m_cmd_first, m_cmd_last, m_cmd_valid;
   logic [7:0]  m_cmd_data;
   logic        m_cmd_ready = 1'b1;
   logic        res_rx_start = 1'b0, res_rx_end = 1'b0, res_rx_error = 1'b0;
   logic [15:0] s_res_pos = '0;
   logic [7:0]  s_res_data = '0;
   logic        s_res_valid = 1'b0;
   logic        offsets_valid;
   logic [7:0]  mon_node = 8'd0;
   logic [31:0] mon_offset, mon_round_trip;

   etherneco_synctimer_master_core #(
      .TIMER_WIDTH(64), .MAX_NODES(MAX_NODES), .TIME_COMPENSATE(32'd0), .LPF_GAIN(2)
   ) dut (
      .clk(clk), .rst(rst), .current_time(current_time), .param_node_count(param_node_count),
      .start_trigger(start_trigger), .start_renew(start_renew), .busy(busy),
      .m_cmd_first(m_cmd_first), .m_cmd_last(m_cmd_last), .m_cmd_data(m_cmd_data),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .res_rx_start(res_rx_start), .res_rx_end(res_rx_end), .res_rx_error(res_rx_error),
      .s_res_pos(s_res_pos), .s_res_data(s_res_data), .s_res_valid(s_res_valid),
      .offsets_valid(offsets_valid), .mon_node(mon_node), .mon_offset(mon_offset),
      .mon_round_trip(mon_round_trip)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {logic [7:0] data; bit first; bit last;} byte_vec_t;
   typedef struct {logic [7:0] node; logic [31:0] exp;} mon_vec_t;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] got_q[$];   // {first, last, data}
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_trigger(input logic [7:0] n, input bit renew);
      param_node_count = n;
      start_renew      = renew;
      start_trigger    = 1'b1;
      tick();
      start_trigger    = 1'b0;
   endtask

   // Accept bytes until last; optionally stall randomly and/or hold start_trigger high.
   task automatic get_frame(input string name, input bit stall, input bit trig_hold);
      int cyc = 0;
      int viol = 0;
      bit done = 1'b0;
      bit have_hold = 1'b0;
      logic [9:0] hold = '0;
      got_q.delete();
      start_trigger = trig_hold;
      while (!done && cyc < 2000) begin
         m_cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (m_cmd_valid) begin
            if (have_hold && {m_cmd_first, m_cmd_last, m_cmd_data} !== hold) viol++;
            if (m_cmd_ready) begin
               got_q.push_back({m_cmd_first, m_cmd_last, m_cmd_data});
               done = m_cmd_last;
               have_hold = 1'b0;
            end else begin
               have_hold = 1'b1;
               hold = {m_cmd_first, m_cmd_last, m_cmd_data};
            end
         end
         tick();
         cyc++;
      end
      m_cmd_ready = 1'b1;
      check({name, "_done"}, 64'(done), 64'd1);
      check({name, "_stall_hold"}, 64'(viol), 64'd0);
   endtask

   function automatic void build_frame(input logic [7:0] b0, input logic [63:0] t, input int n,
                                       input logic [31:0] o1, input logic [31:0] o2);
      logic [31:0] o;
      exp_q.delete();
      exp_q.push_back(b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(t[i*8 +: 8]);
      for (int node = 1; node <= n; node++) begin
         o = (node == 1) ? o1 : (node == 2) ? o2 : 32'd0;
         for (int k = 0; k < 4; k++) exp_q.push_back(o[k*8 +: 8]);
      end
   endfunction

   task automatic compare_frame(input string name);
      logic [9:0] e;
      check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         e = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         check($sformatf("%s_b%0d", name, i), 64'(got_q[i]), 64'(e));
      end
   endtask

   // Response frame: junk header, elapsed for nodes 1..2, a node-3 slot that must be ignored.
   task automatic send_resp(input logic [31:0] el1, input logic [31:0] el2, input int abort_pos);
      res_rx_start = 1'b1;
      tick();
      res_rx_start = 1'b0;
      for (int p = 0; p < 21; p++) begin
         if (p == abort_pos) break;
         s_res_valid = 1'b1;
         s_res_pos   = 16'(p);
         if (p >= 9 && p < 13)       s_res_data = el1[(p-9)*8 +: 8];
         else if (p >= 13 && p < 17) s_res_data = el2[(p-13)*8 +: 8];
         else                        s_res_data = 8'h5A;
         tick();
      end
      s_res_valid = 1'b0;
      if (abort_pos >= 0) res_rx_error = 1'b1;
      else                res_rx_end   = 1'b1;
      tick();
      res_rx_error = 1'b0;
      res_rx_end   = 1'b0;
   endtask

   byte_vec_t f1_tab[17];
   mon_vec_t  mon_tab[7];
   int        seen;

   initial begin
      f1_tab[0] = '{8'h00, 1'b1, 1'b0};
      f1_tab[1] = '{8'h00, 1'b0, 1'b0};
      f1_tab[2] = '{8'h01, 1'b0, 1'b0};
      f1_tab[3] = '{8'h00, 1'b0, 1'b0};
      f1_tab[4] = '{8'h00, 1'b0, 1'b0};
      f1_tab[5] = '{8'h01, 1'b0, 1'b0};
      f1_tab[6] = '{8'h00, 1'b0, 1'b0};
      f1_tab[7] = '{8'h00, 1'b0, 1'b0};
      f1_tab[8] = '{8'h00, 1'b0, 1'b0};
      for (int i = 9; i < 16; i++) f1_tab[i] = '{8'h00, 1'b0, 1'b0};
      f1_tab[16] = '{8'h00, 1'b0, 1'b1};
      mon_tab[0] = '{8'd0,   32'd0};
      mon_tab[1] = '{8'd1,   32'd100};
      mon_tab[2] = '{8'd2,   32'd300};
      mon_tab[3] = '{8'd3,   32'd0};
      mon_tab[4] = '{8'd16,  32'd0};
      mon_tab[5] = '{8'd17,  32'd0};
      mon_tab[6] = '{8'd255, 32'd0};

      repeat (3) tick();
      rst = 1'b0;
      mon_node = 8'd1;
      #1;
      check("rst_busy",   64'(busy), 64'd0);
      check("rst_valid",  64'(m_cmd_valid), 64'd0);
      check("rst_flags",  64'({m_cmd_first, m_cmd_last}), 64'd0);
      check("rst_data",   64'(m_cmd_data), 64'd0);
      check("rst_ov",     64'(offsets_valid), 64'd0);
      check("rst_rt",     64'(mon_round_trip), 64'd0);
      check("rst_offset", 64'(mon_offset), 64'd0);

      // Frame 1: N=2, no stall, table-driven byte check.
      current_time = 64'h0000_0001_0000_0100;
      do_trigger(8'd2, 1'b0);
      check("f1_busy", 64'(busy), 64'd1);
      get_frame("f1", 1'b0, 1'b0);
      check("f1_len", 64'(got_q.size()), 64'd17);
      for (int i = 0; i < 17 && i < got_q.size(); i++)
         check($sformatf("f1_b%0d", i), 64'(got_q[i]),
               64'({f1_tab[i].first, f1_tab[i].last, f1_tab[i].data}));

      // Response 1: round trip 1000, elapsed 800/400.
      current_time = 64'h0000_0001_0000_0100 + 64'd1000;
      send_resp(32'd800, 32'd400, -1);
      repeat (4) tick();
      check("r1_busy", 64'(busy), 64'd0);
      check("r1_ov",   64'(offsets_valid), 64'd1);
      check("r1_rt",   64'(mon_round_trip), 64'd1000);
      for (int i = 0; i < 7; i++) begin
         mon_node = mon_tab[i].node;
         #1;
         check($sformatf("r1_mon_node%0d", mon_tab[i].node), 64'(mon_offset), 64'(mon_tab[i].exp));
      end

      // Frame 2: renew, random back-pressure, trigger held through SEND and WAIT.
      res_rx_start = 1'b1;   // in IDLE: must be ignored
      tick();
      res_rx_start = 1'b0;
      current_time = 64'h1122_3344_5566_7788;
      do_trigger(8'd2, 1'b1);
      get_frame("f2", 1'b1, 1'b1);
      build_frame(8'h03, 64'h1122_3344_5566_7788, 2, 32'd100, 32'd300);
      compare_frame("f2");
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_cmd_valid) seen++;
         tick();
      end
      start_trigger = 1'b0;
      check("f2_no_retrigger", 64'(seen), 64'd0);
      check("f2_busy_wait", 64'(busy), 64'd1);

      // Response 2: aborted after node-1 bytes 0..1; nothing may change.
      current_time = 64'h1122_3344_5566_7788 + 64'd5000;
      send_resp(32'd7, 32'd9, 11);
      check("r2_busy", 64'(busy), 64'd0);
      check("r2_ov",   64'(offsets_valid), 64'd1);
      check("r2_rt",   64'(mon_round_trip), 64'd1000);
      mon_node = 8'd1; #1;
      check("r2_off1", 64'(mon_offset), 64'd100);
      mon_node = 8'd2; #1;
      check("r2_off2", 64'(mon_offset), 64'd300);

      // Frame 3 and response 3: wrap on node 2, busy latency N+1.
      current_time = 64'h0000_00AB_0000_1000;
      do_trigger(8'd2, 1'b0);
      get_frame("f3", 1'b0, 1'b0);
      build_frame(8'h01, 64'h0000_00AB_0000_1000, 2, 32'd100, 32'd300);
      compare_frame("f3");
      current_time = 64'h0000_00AB_0000_1000 + 64'd1010;
      send_resp(32'd410, 32'd1012, -1);
      tick();
      check("r3_busy_calc", 64'(busy), 64'd1);
      tick();
      check("r3_busy_done", 64'(busy), 64'd0);
      check("r3_rt", 64'(mon_round_trip), 64'd1010);
      mon_node = 8'd1; #1;
      check("r3_off1", 64'(mon_offset), 64'(EXP_R3_OFF1));
      mon_node = 8'd2; #1;
      check("r3_off2", 64'(mon_offset), 64'(EXP_R3_OFF2));

      // Frame 4: node count 0 clamps to 1.
      current_time = 64'h0000_0000_0000_0042;
      do_trigger(8'd0, 1'b0);
      get_frame("f4", 1'b0, 1'b0);
      build_frame(8'h01, 64'h0000_0000_0000_0042, 1, EXP_R3_OFF1, 32'd0);
      compare_frame("f4");
      #2 rst = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1;
      check("rst2_ov",  64'(offsets_valid), 64'd0);
      check("rst2_off", 64'(mon_offset), 64'd0);

      // Frame 5: node count 40 clamps to MAX_NODES, all offsets zero after reset.
      tick();
      current_time = 64'hFFFF_FFFF_FFFF_FFF0;
      do_trigger(8'd40, 1'b0);
      get_frame("f5", 1'b0, 1'b0);
      build_frame(8'h00, 64'hFFFF_FFFF_FFFF_FFF0, MAX_NODES, 32'd0, 32'd0);
      compare_frame("f5");
      #2 rst = 1'b1;
      tick();
      #2 rst = 1'b0;
      tick();

      // Frame 6: asynchronous reset while byte 5 is on the bus.
      current_time = 64'h0102_0304_0506_0708;
      do_trigger(8'd2, 1'b0);
      repeat (5) tick();
      check("f6_byte5", 64'(m_cmd_data), 64'h04);
      #2 rst = 1'b1;
      #1;
      check("f6_rst_valid", 64'(m_cmd_valid), 64'd0);
      check("f6_rst_busy",  64'(busy), 64'd0);
      check("f6_rst_last",  64'(m_cmd_last), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/etherneco_synctimer_master_core.md
Name: etherneco_synctimer_master_core

Overview:
Ring-master end of the EtherNeco sync-timer protocol. On a trigger it transmits a command frame: a command byte, the master's 64-bit time, and one 32-bit propagation offset per slave node. It then snoops the returning response frame for each node's 32-bit elapsed time and computes new per-node offsets as (round_trip − elapsed_n)/2. The block sits beside the master timer and drives the ring command TX stream.

Parameters:
TIMER_WIDTH, 64, width of current_time (must be ≥ 32)
MAX_NODES, 16, number of offset/elapsed slots (node ids 1..MAX_NODES)
TIME_COMPENSATE, 0, 32-bit constant added to the transmitted time, to cover frame TX latency
LPF_GAIN, 4, offset filter shift (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
current_time  in  TIMER_WIDTH  master timer
param_node_count  in  8  number of nodes in the ring, 1..MAX_NODES
start_trigger  in  1  pulse: start one sync cycle
start_renew  in  1  sampled with start_trigger; sent as command bit1
busy  out  1  high from the accepted trigger until the cycle ends
m_cmd_first  out  1  first byte of the frame
m_cmd_last  out  1  last byte of the frame
m_cmd_data  out  8  frame byte
m_cmd_valid  out  1  byte valid
m_cmd_ready  in  1  byte accepted when valid&ready
res_rx_start  in  1  response frame start at the master
res_rx_end  in  1  response frame good end
res_rx_error  in  1  response frame error/abort
s_res_pos  in  16  byte position within the response
s_res_data  in  8  response byte
s_res_valid  in  1  response byte strobe
offsets_valid  out  1  at least one complete measurement has been applied
mon_node  in  8  node select for monitor readout
mon_offset  out  32  offset[mon_node], combinational read
mon_round_trip  out  32  last measured round trip

Behaviour:
- Reset values: busy=0, m_cmd_valid=0, m_cmd_first=0, m_cmd_last=0, m_cmd_data=0, offsets_valid=0, mon_round_trip=0, all offsets=0, state=IDLE.
- States: IDLE → SEND → WAIT → RECV → CALC → IDLE.
- IDLE: start_trigger=1 → latch renew, node count N (clamped to 1..MAX_NODES), and tx_time = current_time + TIME_COMPENSATE. Go to SEND; busy=1 on the next cycle. Triggers while busy are ignored.
- SEND: frame of 9+4N bytes, index 0..8+4N, little-endian fields.
  - byte0 = {6'b0, renew, offsets_valid}.
  - bytes 1..8 = tx_time[7:0]..[63:56].
  - byte 9+4(n−1)+k = offset[n] byte k.
  - m_cmd_valid stays high; data, first and last are held stable until ready. first=1 at index 0; last=1 at the final index.
  - On acceptance of byte0, t_start = current_time[31:0].
  - On acceptance of the last byte: valid=0, go to WAIT.
- WAIT: res_rx_start → round_trip = current_time[31:0] − t_start (mod 2^32); go to RECV.
- RECV: when s_res_valid and s_res_pos = 9+4(n−1)+k (n ≤ N, k 0..3), store the byte into elapsed[n] byte k. Bytes at other positions are ignored.
  - res_rx_end → CALC.
  - res_rx_error → discard; offsets unchanged; go to IDLE.
- CALC: one node per cycle, n = 1..N: offset[n] = (round_trip − elapsed[n]) >> 1, unsigned, mod 2^32. A negative difference wraps and is not clamped.
  - After node N: mon_round_trip updated, offsets_valid=1, busy=0, go to IDLE.
  - Latency from res_rx_end to busy=0 is N+1 cycles.
- Frame layout exactly matches the slave parser: offset for node n at position 9+4(n−1); elapsed for node n at the same position in the response.
- A res_rx_start seen while in IDLE or SEND is ignored.
- A trigger in the same cycle that CALC finishes is ignored.
- rst mid-frame: immediate return to reset values; the partial frame is truncated, with no last byte.
- mon_node of 0 or > MAX_NODES reads 0.

Optional Feature:
ETHERNECO_SYNCTIMER_MASTER_LPF_EN
- Defined: CALC updates each offset as offset += (new − offset) >>> LPF_GAIN (signed 32-bit). The first measurement after reset, when offsets_valid=0, loads new directly.
- Undefined: offset = new each cycle; LPF_GAIN is unused.

Test Plan:
- N=2, trigger, ready always 1, current_time=0x0000_0001_0000_0100, TIME_COMPENSATE=0 → 17 bytes: 00, 00 01 00 00 01 00 00 00, then 8 zero bytes. first on byte0, last on byte16, busy clears after CALC.
- Round trip 1000 (res_rx_start 1000 time units after byte0); response elapsed node1=800, node2=400 → offset1=100, offset2=300, mon_round_trip=1000, offsets_valid=1. Next frame byte0=0x01 (0x03 if renew) and carries 64 00 00 00 2C 01 00 00.
- Random m_cmd_ready back-pressure → byte sequence identical to the no-stall run; data held stable while valid&!ready.
- res_rx_error mid-response → offsets unchanged, busy=0, offsets_valid unchanged.
- Trigger asserted during SEND/WAIT → no second frame; rst asserted at byte 5 → m_cmd_valid=0 and busy=0 asynchronously.
- With LPF_EN and LPF_GAIN=2: offset=100, new=300 → offset=150.
